tmds_link_sequencer: RTL and testbench

//  Start-up and run-time sequencer for the three TMDS 10:1 serializer lanes of the DVI/HDMI output.
//  - Waits for the high-speed clock source to report stable lock.
//  - Holds the serializers in reset, then sends a control-period preamble.
//  - Only then passes encoded TMDS words from the encoders to the serializers.

---
 rtl/tmds_link_sequencer_pkg.sv | 25 ++
 rtl/tmds_link_sequencer_if.sv | 25 ++
 rtl/tmds_link_sequencer.sv | 106 ++++++++++
 tb/tb_tmds_link_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tmds_link_sequencer_pkg.sv
// Shared TMDS constants: control-period tokens, sequencer state encodings, lane bundle.
// Latency n/a; no handshake.
package tmds_link_sequencer_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SER_RST   = 3'd1,
    CTRL      = 3'd2,
    ACTIVE    = 3'd3
  } seq_state_e;

  typedef struct packed {
    logic [9:0] ch2;
    logic [9:0] ch1;
    logic [9:0] ch0;
  } tmds_lanes_t;

  localparam tmds_lanes_t LANES_IDLE = '{ch2: CTRL_TOKEN_00, ch1: CTRL_TOKEN_00, ch0: CTRL_TOKEN_00};

endpackage

// File: rtl/tmds_link_sequencer_if.sv
// Encoder-to-serializer link bundle through the sequencer, plus lock/mute control and status.
// master = sequencer side, slave = surrounding display top.
interface tmds_link_sequencer_if;
  logic       i_locked;
  logic       i_mute;
  logic [9:0] i_tmds_ch0;
  logic [9:0] i_tmds_ch1;
  logic [9:0] i_tmds_ch2;
  logic [9:0] o_tmds_ch0;
  logic [9:0] o_tmds_ch1;
  logic [9:0] o_tmds_ch2;
  logic       o_ser_rst;
  logic       o_link_up;
  logic [2:0] o_state;

  modport master (
    input  i_locked, i_mute, i_tmds_ch0, i_tmds_ch1, i_tmds_ch2,
    output o_tmds_ch0, o_tmds_ch1, o_tmds_ch2, o_ser_rst, o_link_up, o_state
  );

  modport slave (
    output i_locked, i_mute, i_tmds_ch0, i_tmds_ch1, i_tmds_ch2,
    input  o_tmds_ch0, o_tmds_ch1, o_tmds_ch2, o_ser_rst, o_link_up, o_state
  );
endinterface

// File: rtl/tmds_link_sequencer.sv
// Brings up the TMDS serializers (lock wait, serializer reset, control preamble) then passes encoder words.
// One-cycle registered latency on all outputs; no backpressure, lanes always update together.
module tmds_link_sequencer
  import tmds_link_sequencer_pkg::*;
#(
  parameter int LOCK_CYCLES    = 16,
  parameter int SER_RST_CYCLES = 8,
  parameter int CTRL_CYCLES    = 64,
  parameter int CNT_W          = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  tmds_link_sequencer_if.master lnk
);

  if (LOCK_CYCLES < 1 || SER_RST_CYCLES < 1 || CTRL_CYCLES < 1 ||
      LOCK_CYCLES > 2**CNT_W || SER_RST_CYCLES > 2**CNT_W || CTRL_CYCLES > 2**CNT_W) begin : g_bad_param
    $error("tmds_link_sequencer: *_CYCLES must be in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SRST_LAST = CNT_W'(SER_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CTRL_LAST = CNT_W'(CTRL_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_rst_q;
  logic             link_up_q;
  tmds_lanes_t      lanes_q;
  tmds_lanes_t      lanes_in;

  assign lanes_in = '{ch2: lnk.i_tmds_ch2, ch1: lnk.i_tmds_ch1, ch0: lnk.i_tmds_ch0};

  // Lock loss is checked first in every state so it always wins over count expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      WAIT_LOCK: begin
        if (!lnk.i_locked) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = SER_RST;
          cnt_d   = '0;
        end
      end
      SER_RST: begin
        if (!lnk.i_locked) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SRST_LAST) begin
          state_d = CTRL;
          cnt_d   = '0;
        end
      end
      CTRL: begin
        if (!lnk.i_locked) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CTRL_LAST) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        cnt_d = '0;
        if (!lnk.i_locked) begin
          state_d = WAIT_LOCK;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow the next state so they switch on the same edge as state_q.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      ser_rst_q <= 1'b1;
      link_up_q <= 1'b0;
      lanes_q   <= LANES_IDLE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ser_rst_q <= (state_d == WAIT_LOCK) || (state_d == SER_RST);
      link_up_q <= (state_d == ACTIVE);
      if ((state_d == ACTIVE) && !lnk.i_mute) begin
        lanes_q <= lanes_in;
      end else begin
        lanes_q <= LANES_IDLE;
      end
    end
  end

  assign lnk.o_tmds_ch0 = lanes_q.ch0;
  assign lnk.o_tmds_ch1 = lanes_q.ch1;
  assign lnk.o_tmds_ch2 = lanes_q.ch2;
  assign lnk.o_ser_rst  = ser_rst_q;
  assign lnk.o_link_up  = link_up_q;
  assign lnk.o_state    = state_q;

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Bench for tmds_link_sequencer: default-parameter and all-ones-parameter instances share stimulus.
// Reference model tracks only the run of consecutive locked edges since the last reset or lock drop.
module tb_tmds_link_sequencer;
  import tmds_link_sequencer_pkg::*;

  localparam int LK [2] = '{16, 1};
  localparam int SR [2] = '{8, 1};
  localparam int CT [2] = '{64, 1};
  localparam logic [29:0] IDLE3 = {CTRL_TOKEN_00, CTRL_TOKEN_00, CTRL_TOKEN_00};

  logic clk = 1'b0;
  logic rst;
  logic locked;
  logic mute;
  logic [9:0] d0, d1, d2;

  always #5 clk = ~clk;

  tmds_link_sequencer_if ifa ();
  tmds_link_sequencer_if ifb ();

  assign ifa.i_locked = locked;
  assign ifa.i_mute = mute;
  assign ifa.i_tmds_ch0 = d0;
  assign ifa.i_tmds_ch1 = d1;
  assign ifa.i_tmds_ch2 = d2;
  assign ifb.i_locked = locked;
  assign ifb.i_mute = mute;
  assign ifb.i_tmds_ch0 = d0;
  assign ifb.i_tmds_ch1 = d1;
  assign ifb.i_tmds_ch2 = d2;

  tmds_link_sequencer dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .lnk   (ifa)
  );

  tmds_link_sequencer #(
    .LOCK_CYCLES    (1),
    .SER_RST_CYCLES (1),
    .CTRL_CYCLES    (1),
    .CNT_W          (8)
  ) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .lnk   (ifb)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int run [2];
  logic [29:0] exp_lanes [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // State implied by how long lock has been held continuously.
  function automatic int exp_state(input int r, input int k);
    if (r < LK[k]) return 0;
    if (r < LK[k] + SR[k]) return 1;
    if (r < LK[k] + SR[k] + CT[k]) return 2;
    return 3;
  endfunction

  task automatic rand_data();
    d0 = 10'($urandom);
    d1 = 10'($urandom);
    d2 = 10'($urandom);
  endtask

  task automatic compare_all();
    logic [2:0]  st;
    logic        sr, lu;
    logic [29:0] ln;
    int          es;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        st = ifa.o_state; sr = ifa.o_ser_rst; lu = ifa.o_link_up;
        ln = {ifa.o_tmds_ch2, ifa.o_tmds_ch1, ifa.o_tmds_ch0};
      end else begin
        st = ifb.o_state; sr = ifb.o_ser_rst; lu = ifb.o_link_up;
        ln = {ifb.o_tmds_ch2, ifb.o_tmds_ch1, ifb.o_tmds_ch0};
      end
      es = exp_state(run[k], k);
      chk($sformatf("d%0d_state c%0d", k, cyc), 32'(st), 32'(es));
      chk($sformatf("d%0d_ser_rst c%0d", k, cyc), 32'(sr), 32'(es < 2));
      chk($sformatf("d%0d_link_up c%0d", k, cyc), 32'(lu), 32'(es == 3));
      chk($sformatf("d%0d_lanes c%0d", k, cyc), 32'(ln), 32'(exp_lanes[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        run[k] = 0;
        exp_lanes[k] = IDLE3;
      end else begin
        if (!locked) run[k] = 0;
        else if (run[k] < 100000) run[k] = run[k] + 1;
        exp_lanes[k] = (exp_state(run[k], k) == 3 && !mute) ? {d2, d1, d0} : IDLE3;
      end
    end
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; locked = 1'b1; mute = 1'b0;
    rand_data();
    step();

    // Default bring-up with lock held, checked at the documented edges.
    do_reset();
    chk("s1 b_state c0", 32'(ifb.o_state), 32'd0);
    for (int k = 1; k <= 95; k++) begin
      if (k == 91) begin d0 = 10'h2AB; d1 = 10'h0F0; d2 = 10'h10F; end
      else rand_data();
      step();
      if (k <= 3)  chk("s1 b_state seq", 32'(ifb.o_state), 32'(k));
      if (k == 23) chk("s1 ser_rst c23", 32'(ifa.o_ser_rst), 32'd1);
      if (k == 24) chk("s1 ser_rst c24", 32'(ifa.o_ser_rst), 32'd0);
      if (k == 87) chk("s1 link_up c87", 32'(ifa.o_link_up), 32'd0);
      if (k == 88) chk("s1 link_up c88", 32'(ifa.o_link_up), 32'd1);
      if (k == 91) chk("s1 ch0 2AB", 32'(ifa.o_tmds_ch0), 32'h2AB);
    end

    // Lock glitch at cnt==10.
    do_reset();
    for (int k = 1; k <= 10; k++) step();
    locked = 1'b0; step();
    locked = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) chk("s2 still wait", 32'(ifa.o_state), 32'd0);
      if (k == 16) chk("s2 ser_rst entry", 32'(ifa.o_state), 32'd1);
    end

    // Lock loss in ACTIVE, then full re-sequence.
    for (int k = 0; k < 80; k++) begin rand_data(); step(); end
    chk("s3 active", 32'(ifa.o_state), 32'd3);
    locked = 1'b0; step();
    chk("s3 loss state", 32'(ifa.o_state), 32'd0);
    chk("s3 loss ser_rst", 32'(ifa.o_ser_rst), 32'd1);
    chk("s3 loss link_up", 32'(ifa.o_link_up), 32'd0);
    chk("s3 loss lanes", 32'({ifa.o_tmds_ch2, ifa.o_tmds_ch1, ifa.o_tmds_ch0}), 32'({10'h354, 10'h354, 10'h354}));
    locked = 1'b1;
    for (int k = 1; k <= 88; k++) begin
      rand_data(); step();
      if (k == 87) chk("s3 relock c87", 32'(ifa.o_state), 32'd2);
      if (k == 88) chk("s3 relock c88", 32'(ifa.o_state), 32'd3);
    end

    // Mute for 5 cycles in ACTIVE.
    d0 = 10'h1F0; d1 = 10'h1F0; d2 = 10'h1F0;
    step();
    chk("s4 pre", 32'(ifa.o_tmds_ch1), 32'h1F0);
    mute = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) mute = 1'b0;
      step();
      chk("s4 link_up", 32'(ifa.o_link_up), 32'd1);
      chk("s4 ch2", 32'(ifa.o_tmds_ch2), (k <= 5) ? 32'h354 : 32'h1F0);
    end

    // Reset in the middle of CTRL.
    do_reset();
    for (int k = 1; k <= 54; k++) step();
    chk("s5 mid ctrl", 32'(ifa.o_state), 32'd2);
    do_reset();
    chk("s5 rst state", 32'(ifa.o_state), 32'd0);
    chk("s5 rst ser_rst", 32'(ifa.o_ser_rst), 32'd1);
    chk("s5 rst ch0", 32'(ifa.o_tmds_ch0), 32'h354);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) chk("s5 restart wait", 32'(ifa.o_state), 32'd0);
      if (k == 16) chk("s5 restart srst", 32'(ifa.o_state), 32'd1);
    end

    // Minimum parameters: lock loss during the single SER_RST cycle.
    do_reset();
    step();
    chk("s6 b in srst", 32'(ifb.o_state), 32'd1);
    locked = 1'b0; step();
    chk("s6 b loss state", 32'(ifb.o_state), 32'd0);
    chk("s6 b loss ser_rst", 32'(ifb.o_ser_rst), 32'd1);
    locked = 1'b1;

    // Randomized traffic with sparse lock drops, mute bursts and resets.
    for (int k = 0; k < 2500; k++) begin
      rand_data();
      locked = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 15) == 0) mute = ~mute;
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
